// File: rtl/system_widths_pkg.sv
// Shared widths and the instruction-queue FSM state type.
`timescale 1ns/1ps
package system_widths_pkg;

  localparam int INSTR_W = 32;
  localparam int STAT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } iq_state_t;

endpackage : system_widths_pkg

// File: rtl/sync_fifo.sv
// Synchronous circular FIFO: storage, wrap-around pointers and occupancy count.
// Flush clears pointers and count and takes priority over push and pop.
`timescale 1ns/1ps
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage written at the tail.
  // NOTE: storage has no reset; contents are only observed once count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule : sync_fifo

// File: rtl/instruction_queue.sv
// Instruction queue between a host and an instruction unit (IU).
// Buffers host words in a FIFO and issues them one at a time, waiting for
// the IU's done pulse before issuing the next.
// Optional macro INSTRUCTION_QUEUE_STATS_EN adds saturating issued/illegal counters.
`timescale 1ns/1ps
module instruction_queue
  import system_widths_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    host_valid,
  input  logic [INSTR_W-1:0]      host_instr,
  output logic                    host_ready,
  input  logic                    flush,
  input  logic                    iu_core_ready,
  input  logic                    iu_instr_done,
  input  logic                    iu_illegal,
  output logic                    instr_valid,
  output logic [INSTR_W-1:0]      instr_in,
`ifdef INSTRUCTION_QUEUE_STATS_EN
  output logic [STAT_W-1:0]       issued_count,
  output logic [STAT_W-1:0]       illegal_count,
`endif
  output logic [$clog2(DEPTH):0]  q_count,
  output logic                    q_empty,
  output logic                    q_full,
  output logic                    busy
);

  iq_state_t state_q;
  logic      push;
  logic      issue_accept;

  assign host_ready   = !q_full && !flush;
  assign push         = host_valid && host_ready;
  assign instr_valid  = (state_q == ISSUE) && !flush;
  assign issue_accept = instr_valid && iu_core_ready;
  assign busy         = (state_q != IDLE) || !q_empty;

  sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetN (resetN),
    .push   (push),
    .pop    (issue_accept),
    .flush  (flush),
    .wdata  (host_instr),
    .rdata  (instr_in),
    .full   (q_full),
    .empty  (q_empty),
    .count  (q_count)
  );

  // Issue FSM: offer the head, hand it to the IU, then wait for completion.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (!q_empty && !flush) state_q <= ISSUE;
        ISSUE:   if (flush)              state_q <= IDLE;
                 else if (iu_core_ready) state_q <= WAIT;
        WAIT:    if (iu_instr_done)      state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef INSTRUCTION_QUEUE_STATS_EN
  logic [STAT_W-1:0] issued_count_q;
  logic [STAT_W-1:0] illegal_count_q;

  assign issued_count  = issued_count_q;
  assign illegal_count = illegal_count_q;

  // Saturating statistics; flush leaves them untouched.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      issued_count_q  <= '0;
      illegal_count_q <= '0;
    end else begin
      if (issue_accept && (issued_count_q != '1))
        issued_count_q <= issued_count_q + 1'b1;
      if ((state_q == WAIT) && iu_instr_done && iu_illegal && (illegal_count_q != '1))
        illegal_count_q <= illegal_count_q + 1'b1;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = iu_illegal;
`endif

endmodule : instruction_queue

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue: directed scenarios followed by
// random traffic, all compared against a transaction-level queue model.
`timescale 1ns/1ps
module tb_instruction_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        host_valid = 1'b0;
  logic [31:0] host_instr = '0;
  logic        host_ready;
  logic        flush = 1'b0;
  logic        iu_core_ready = 1'b0;
  logic        iu_instr_done = 1'b0;
  logic        iu_illegal = 1'b0;
  logic        instr_valid;
  logic [31:0] instr_in;
  logic [15:0] issued_count;
  logic [15:0] illegal_count;
  logic [2:0]  q_count;
  logic        q_empty;
  logic        q_full;
  logic        busy;

  instruction_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .resetN        (resetN),
    .host_valid    (host_valid),
    .host_instr    (host_instr),
    .host_ready    (host_ready),
    .flush         (flush),
    .iu_core_ready (iu_core_ready),
    .iu_instr_done (iu_instr_done),
    .iu_illegal    (iu_illegal),
    .instr_valid   (instr_valid),
    .instr_in      (instr_in),
`ifdef INSTRUCTION_QUEUE_STATS_EN
    .issued_count  (issued_count),
    .illegal_count (illegal_count),
`endif
    .q_count       (q_count),
    .q_empty       (q_empty),
    .q_full        (q_full),
    .busy          (busy)
  );

`ifndef INSTRUCTION_QUEUE_STATS_EN
  assign issued_count  = '0;
  assign illegal_count = '0;
`endif

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queued words, plus whether the head is being offered
  // to the IU and whether an instruction is outstanding at the IU.
  logic [31:0] mq[$];
  bit          m_offer;
  bit          m_fly;
  int          m_issued;
  int          m_illegal;
  logic [31:0] obs_issue[$];

  // Last sampled DUT values, for explicit scenario checks.
  logic        last_valid, last_busy, last_ready, last_empty, last_full;
  logic [2:0]  last_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_offer   = 1'b0;
    m_fly     = 1'b0;
    m_issued  = 0;
    m_illegal = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_host_ready"},  host_ready,  1);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_q_count"},     q_count,     0);
    check({tag, "_q_empty"},     q_empty,     1);
    check({tag, "_q_full"},      q_full,      0);
    check({tag, "_busy"},        busy,        0);
`ifdef INSTRUCTION_QUEUE_STATS_EN
    check({tag, "_issued_count"},  issued_count,  0);
    check({tag, "_illegal_count"}, illegal_count, 0);
`endif
  endtask

  task automatic apply_reset();
    @(negedge clk);
    resetN = 1'b0;
    host_valid = 0; iu_core_ready = 0; iu_instr_done = 0; iu_illegal = 0; flush = 0;
    #1;
    check_reset_values("reset");
    @(negedge clk);
    resetN = 1'b1;
    model_reset();
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, advance the model.
  task automatic cycle(input bit hv, input logic [31:0] wd, input bit cr,
                       input bit dn, input bit il, input bit fl);
    bit e_full, e_ready, e_valid, cur_empty, do_push, do_pop;
    @(negedge clk);
    host_valid = hv; host_instr = wd; iu_core_ready = cr;
    iu_instr_done = dn; iu_illegal = il; flush = fl;
    #1;
    cur_empty = (mq.size() == 0);
    e_full    = (mq.size() == DEPTH);
    e_ready   = !e_full && !fl;
    e_valid   = m_offer && !fl;
    check("host_ready",  host_ready,  e_ready);
    check("instr_valid", instr_valid, e_valid);
    check("q_count",     q_count,     mq.size());
    check("q_empty",     q_empty,     cur_empty);
    check("q_full",      q_full,      e_full);
    check("busy",        busy,        m_offer || m_fly || !cur_empty);
    if (e_valid) check("instr_in", instr_in, mq[0]);
`ifdef INSTRUCTION_QUEUE_STATS_EN
    check("issued_count",  issued_count,  m_issued);
    check("illegal_count", illegal_count, m_illegal);
`endif
    last_valid = instr_valid; last_busy = busy; last_ready = host_ready;
    last_empty = q_empty; last_full = q_full; last_count = q_count;
    if (instr_valid === 1'b1 && cr) obs_issue.push_back(instr_in);

    do_push = hv && e_ready;
    do_pop  = e_valid && cr;
    if (m_offer) begin
      if (!fl && cr) begin
        m_offer = 1'b0;
        m_fly   = 1'b1;
      end else if (fl) begin
        m_offer = 1'b0;
      end
    end else if (m_fly) begin
      if (dn) begin
        m_fly = 1'b0;
        if (il && m_illegal < 16'hFFFF) m_illegal++;
      end
    end else if (!cur_empty && !fl) begin
      m_offer = 1'b1;
    end
    if (fl) begin
      mq.delete();
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        if (m_issued < 16'hFFFF) m_issued++;
      end
      if (do_push) mq.push_back(wd);
    end
  endtask

  initial begin
    logic [31:0] order_exp[6];
    model_reset();

    // Reset state
    apply_reset();

    // Single instruction: push at edge 0, offered after edge 1, popped at edge 2
    cycle(1, 32'h1080_0000, 1, 0, 0, 0);
    cycle(0, 32'h0, 1, 0, 0, 0);
    check("single_not_yet_valid", last_valid, 0);
    check("single_count_before_pop", last_count, 1);
    cycle(0, 32'h0, 1, 0, 0, 0);
    check("single_valid", last_valid, 1);
    cycle(0, 32'h0, 0, 1, 0, 0);
    check("single_count_after_pop", last_count, 0);
    check("single_busy_wait", last_busy, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    check("single_done_busy", last_busy, 0);

    // Fill: five pushes with IU busy, only four accepted
    for (int i = 0; i < 5; i++) cycle(1, 32'hF000_0000 + i, 0, 0, 0, 0);
    check("fill_fifth_ready", last_ready, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    check("fill_count", last_count, 4);
    check("fill_full", last_full, 1);
    check("fill_ready", last_ready, 0);
    // Drain everything
    for (int i = 0; i < 16; i++) cycle(0, 32'h0, 1, 1, 0, 0);
    check("fill_drained", last_empty, 1);

    // Ordering and pointer wrap: A..F with interleaved completions
    obs_issue.delete();
    order_exp = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF};
    for (int i = 0; i < 3; i++) cycle(1, order_exp[i], 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 32'h0, 1, 1, 0, 0);
    for (int i = 3; i < 6; i++) cycle(1, order_exp[i], 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) cycle(0, 32'h0, 1, 1, 0, 0);
    check("order_issue_count", obs_issue.size(), 6);
    for (int i = 0; i < 6; i++)
      check("order_word", (i < obs_issue.size()) ? obs_issue[i] : 32'hDEAD_BEEF, order_exp[i]);

    // Simultaneous push and pop at occupancy 2
    cycle(1, 32'h2222_0001, 0, 0, 0, 0);
    cycle(1, 32'h2222_0002, 0, 0, 0, 0);
    cycle(1, 32'h2222_0003, 1, 0, 0, 0);
    check("pushpop_before", last_count, 2);
    cycle(0, 32'h0, 0, 0, 0, 0);
    check("pushpop_after", last_count, 2);
    for (int i = 0; i < 12; i++) cycle(0, 32'h0, 1, 1, 0, 0);

    // Flush in ISSUE with three queued
    for (int i = 0; i < 3; i++) cycle(1, 32'h3333_0000 + i, 0, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 1);
    check("flush_issue_valid", last_valid, 0);
    check("flush_issue_count_before", last_count, 3);
    cycle(0, 32'h0, 1, 0, 0, 0);
    check("flush_issue_count_after", last_count, 0);
    check("flush_issue_no_offer", last_valid, 0);
    check("flush_issue_idle", last_busy, 0);

    // Flush in WAIT: queue cleared, done still returns to idle
    cycle(1, 32'h4444_0000, 1, 0, 0, 0);
    cycle(1, 32'h4444_0001, 1, 0, 0, 0);
    cycle(1, 32'h4444_0002, 1, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 1);
    cycle(0, 32'h0, 0, 0, 0, 0);
    check("flush_wait_count", last_count, 0);
    check("flush_wait_busy", last_busy, 1);
    cycle(0, 32'h0, 0, 1, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    check("flush_wait_idle", last_busy, 0);

`ifdef INSTRUCTION_QUEUE_STATS_EN
    // Stats: three issues, first completion flagged illegal
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1, 32'h5555_0000 + i, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 32'h0, 1, 1, m_fly && (m_illegal == 0), 0);
    check("stats_issued", issued_count, 3);
    check("stats_illegal", illegal_count, 1);
`endif

    // Asynchronous reset while WAIT with two queued
    cycle(1, 32'h6666_0000, 1, 0, 0, 0);
    cycle(1, 32'h6666_0001, 1, 0, 0, 0);
    cycle(1, 32'h6666_0002, 1, 0, 0, 0);
    cycle(0, 32'h0, 0, 0, 0, 0);
    check("prereset_count", last_count, 2);
    check("prereset_busy", last_busy, 1);
    @(negedge clk);
    host_valid = 0; iu_core_ready = 0; iu_instr_done = 0; flush = 0;
    #2 resetN = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    resetN = 1'b1;
    model_reset();

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit dn;
      dn = ($urandom_range(0, 3) == 0);
      cycle($urandom_range(0, 1), $urandom, $urandom_range(0, 2) != 0,
            dn, dn && ($urandom_range(0, 2) == 0), $urandom_range(0, 19) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_instruction_queue
